// File: rtl/xyolo_conv_seq_if.sv
// Control/memory-side signal bundle of the xyolo convolution sequencer.
// master: the sequencer itself; slave: the controller and datapath around it.
interface xyolo_conv_seq_if #(
  parameter int MEM_ADDR_W    = 10,
  parameter int VWRITE_ADDR_W = 10,
  parameter int CNT_W         = 12
);
  logic                     run;
  logic [CNT_W-1:0]         cfg_nout_m1;
  logic [CNT_W-1:0]         cfg_nacc_m1;
  logic [MEM_ADDR_W-1:0]    cfg_pix_base;
  logic [MEM_ADDR_W-1:0]    cfg_pix_incr;
  logic [VWRITE_ADDR_W-1:0] cfg_out_base;
  logic                     cfg_maxpool;
  logic                     vread_enB;
  logic [MEM_ADDR_W-1:0]    vread_addrB;
  logic [CNT_W-1:0]         w_addr;
  logic                     ld_acc;
  logic                     ld_res;
  logic                     ld_mp;
  logic                     vwrite_enB;
  logic [VWRITE_ADDR_W-1:0] vwrite_addrB;
  logic                     busy;
  logic                     done;

  modport master (
    input  run, cfg_nout_m1, cfg_nacc_m1, cfg_pix_base, cfg_pix_incr, cfg_out_base, cfg_maxpool,
    output vread_enB, vread_addrB, w_addr, ld_acc, ld_res, ld_mp, vwrite_enB, vwrite_addrB, busy, done
  );
  modport slave (
    output run, cfg_nout_m1, cfg_nacc_m1, cfg_pix_base, cfg_pix_incr, cfg_out_base, cfg_maxpool,
    input  vread_enB, vread_addrB, w_addr, ld_acc, ld_res, ld_mp, vwrite_enB, vwrite_addrB, busy, done
  );
endinterface

// File: rtl/xyolo_conv_seq.sv
// Read/MAC/write sequencer for one xyolo convolution pass.
// Define XYOLO_SEQ_MAXPOOL_EN to enable 4:1 maxpool grouping of results.
module xyolo_conv_seq #(
  parameter int MEM_ADDR_W    = 10,
  parameter int VWRITE_ADDR_W = 10,
  parameter int CNT_W         = 12,
  parameter int RES_LAT       = 2
) (
  input  logic               clk,
  input  logic               rst,
  xyolo_conv_seq_if.master   bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         nout_q, nout_d, nacc_q, nacc_d;
  logic [CNT_W-1:0]         o_q, o_d, k_q, k_d;
  logic [CNT_W-1:0]         wr_idx_q, wr_idx_d, last_wr_q, last_wr_d;
  logic [MEM_ADDR_W-1:0]    incr_q, incr_d, row_q, row_d, addr_q, addr_d;
  logic [VWRITE_ADDR_W-1:0] out_base_q, out_base_d;
  logic [1:0]               first_q;
  logic [2:0]               last_q;
  logic [RES_LAT-1:0]       wr_dl_q;
  logic                     wr_trig, vwrite_en, run_acc;

  assign vwrite_en = wr_dl_q[RES_LAT-1];
  assign run_acc   = (state_q == IDLE) && bus.run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      nout_q     <= '0;
      nacc_q     <= '0;
      o_q        <= '0;
      k_q        <= '0;
      wr_idx_q   <= '0;
      last_wr_q  <= '0;
      incr_q     <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      out_base_q <= '0;
    end else begin
      state_q    <= state_d;
      nout_q     <= nout_d;
      nacc_q     <= nacc_d;
      o_q        <= o_d;
      k_q        <= k_d;
      wr_idx_q   <= wr_idx_d;
      last_wr_q  <= last_wr_d;
      incr_q     <= incr_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
      out_base_q <= out_base_d;
    end
  end

  // The current read (o_q, k_q, addr_q) is itself the registered read port.
  always_comb begin
    state_d    = state_q;
    nout_d     = nout_q;
    nacc_d     = nacc_q;
    o_d        = o_q;
    k_d        = k_q;
    last_wr_d  = last_wr_q;
    incr_d     = incr_q;
    row_d      = row_q;
    addr_d     = addr_q;
    out_base_d = out_base_q;
    wr_idx_d   = vwrite_en ? wr_idx_q + CNT_W'(1) : wr_idx_q;
    case (state_q)
      IDLE: begin
        if (bus.run) begin
          state_d    = ISSUE;
          nout_d     = bus.cfg_nout_m1;
          nacc_d     = bus.cfg_nacc_m1;
          incr_d     = bus.cfg_pix_incr;
          out_base_d = bus.cfg_out_base;
          o_d        = '0;
          k_d        = '0;
          row_d      = bus.cfg_pix_base;
          addr_d     = bus.cfg_pix_base;
          wr_idx_d   = '0;
`ifdef XYOLO_SEQ_MAXPOOL_EN
          last_wr_d  = bus.cfg_maxpool ? (bus.cfg_nout_m1 >> 2) : bus.cfg_nout_m1;
`else
          last_wr_d  = bus.cfg_nout_m1;
`endif
        end
      end
      ISSUE: begin
        if (k_q == nacc_q) begin
          k_d    = '0;
          o_d    = o_q + CNT_W'(1);
          row_d  = row_q + incr_q;
          addr_d = row_q + incr_q;
          if (o_q == nout_q) state_d = DRAIN;
        end else begin
          k_d    = k_q + CNT_W'(1);
          addr_d = addr_q + MEM_ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (vwrite_en && (wr_idx_q == last_wr_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tags ride along with each read: k=0 opens a sum, k=nacc closes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_q <= '0;
      last_q  <= '0;
    end else begin
      first_q <= {first_q[0], (state_q == ISSUE) && (k_q == '0)};
      last_q  <= {last_q[1:0], (state_q == ISSUE) && (k_q == nacc_q)};
    end
  end

`ifdef XYOLO_SEQ_MAXPOOL_EN
  logic       mp_q, ld_mp_q;
  logic [1:0] mp_grp_q;
  logic [CNT_W-1:0] res_idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mp_q      <= 1'b0;
      ld_mp_q   <= 1'b0;
      mp_grp_q  <= '0;
      res_idx_q <= '0;
    end else begin
      ld_mp_q <= last_q[2] && mp_q;
      if (run_acc) begin
        mp_q      <= bus.cfg_maxpool;
        mp_grp_q  <= '0;
        res_idx_q <= '0;
      end else if (ld_mp_q) begin
        mp_grp_q  <= mp_grp_q + 2'd1;
        res_idx_q <= res_idx_q + CNT_W'(1);
      end
    end
  end

  // A group closes on its 4th member or on the final result of the pass.
  assign wr_trig   = mp_q ? (ld_mp_q && ((mp_grp_q == 2'd3) || (res_idx_q == nout_q)))
                          : last_q[2];
  assign bus.ld_mp = ld_mp_q;
`else
  assign wr_trig   = last_q[2];
  assign bus.ld_mp = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < RES_LAT; gi++) begin : g_wr_dl
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)          wr_dl_q[gi] <= 1'b0;
        else if (gi == 0)  wr_dl_q[gi] <= wr_trig;
        else               wr_dl_q[gi] <= wr_dl_q[(gi == 0) ? 0 : gi-1];
      end
    end
  endgenerate

  assign bus.vread_enB    = (state_q == ISSUE);
  assign bus.vread_addrB  = addr_q;
  assign bus.w_addr       = k_q;
  assign bus.ld_acc       = first_q[1];
  assign bus.ld_res       = last_q[2];
  assign bus.vwrite_enB   = vwrite_en;
  assign bus.vwrite_addrB = out_base_q + VWRITE_ADDR_W'(wr_idx_q);
  assign bus.done         = (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
endmodule

// File: doc/xyolo_conv_seq.md
XYOLO_CONV_SEQ -- requirements
Module: xyolo_conv_seq

Interface
REQ-001 SHALL have parameter MEM_ADDR_W, default 10, meaning vread_addrB width.
REQ-002 SHALL have parameter VWRITE_ADDR_W, default 10, meaning vwrite_addrB width.
REQ-003 SHALL have parameter CNT_W, default 12, meaning width of all count fields.
REQ-004 SHALL have parameter RES_LAT, default 2, meaning cycles from ld_res to a valid xyolo flow_out.
REQ-005 SHALL have ports as listed; one clock, reset asynchronous active-low:
 clk  in  1  clock.
 rst  in  1  asynchronous active-low reset.
 run  in  1  start pulse, sampled in IDLE only.
 cfg_nout_m1  in  CNT_W  output pixels minus 1.
 cfg_nacc_m1  in  CNT_W  MACs per output pixel minus 1.
 cfg_pix_base  in  MEM_ADDR_W  first pixel address.
 cfg_pix_incr  in  MEM_ADDR_W  pixel address step per output pixel.
 cfg_out_base  in  VWRITE_ADDR_W  first vwrite address.
 cfg_maxpool  in  1  group 4 consecutive results into 1 write.
 vread_enB  out  1  pixel memory read enable.
 vread_addrB  out  MEM_ADDR_W  pixel memory read address.
 w_addr  out  CNT_W  weight index, equal to MAC index k.
 ld_acc  out  1  start a new sum with the product in this cycle.
 ld_res  out  1  latch the finished sum into the result register.
 ld_mp  out  1  fold the result register into the maxpool register.
 vwrite_enB  out  1  vwrite memory write enable.
 vwrite_addrB  out  VWRITE_ADDR_W  vwrite memory write address.
 busy  out  1  sequence in progress.
 done  out  1  high in IDLE, low otherwise.

Function
REQ-006 SHALL implement FSM IDLE -> ISSUE (on run) -> DRAIN (after the last read is issued) -> IDLE (after the last vwrite_enB pulse).
REQ-007 SHALL, in ISSUE, issue one read per cycle with no bubbles:
- order is o = 0..cfg_nout_m1 (outer), k = 0..cfg_nacc_m1 (inner);
- vread_enB = 1;
- vread_addrB = cfg_pix_base + o*cfg_pix_incr + k, modulo 2^MEM_ADDR_W (wraps silently);
- w_addr = k.
REQ-008 SHALL assert ld_acc for exactly one cycle, 2 cycles after the k = 0 read of each output pixel, matching the 2-cycle read path (memory read plus output register).
REQ-009 SHALL assert ld_res for exactly one cycle, 3 cycles after the k = cfg_nacc_m1 read of each output pixel.
REQ-010 SHALL, with cfg_maxpool = 0, assert vwrite_enB RES_LAT cycles after each ld_res, with vwrite_addrB = cfg_out_base + o.
REQ-011 SHALL, with cfg_maxpool = 1:
- assert ld_mp 1 cycle after each ld_res;
- group outputs in sets of 4;
- assert vwrite_enB RES_LAT cycles after the ld_mp of the 4th member of each group (or of the last output, for a partial final group);
- set vwrite_addrB = cfg_out_base + group index.
REQ-012 SHALL sample all cfg_* inputs into internal registers on the accepted run pulse; cfg changes while busy have no effect.
REQ-013 SHALL ignore run while busy = 1.
REQ-014 SHALL allow run to be accepted in the same cycle that FSM returns to IDLE.
REQ-015 SHALL, for cfg_nacc_m1 = 0, assert ld_acc and ld_res on consecutive cycles for every output pixel.
REQ-016 SHALL drive vread_enB, ld_acc, ld_res, ld_mp and vwrite_enB low in all cycles not stated above.
REQ-017 SHALL generate every output from registered state (no combinational path from input to output).

Reset
REQ-018 SHALL, on rst low, immediately:
- enter IDLE;
- clear all counters and delay lines;
- drive vread_enB, ld_acc, ld_res, ld_mp, vwrite_enB and busy to 0;
- drive done to 1;
- drive all address outputs to 0.
REQ-019 SHALL, when reset is asserted mid-sequence, abort the sequence with no further enables after release; the next run starts a fresh sequence.

Configuration
REQ-020 SHALL support macro XYOLO_SEQ_MAXPOOL_EN:
- defined: REQ-011 behaviour is available;
- undefined: cfg_maxpool is ignored, ld_mp is tied 0, grouping logic is removed, and REQ-010 always applies.

Verification
REQ-021 SHALL cover run with nout_m1 = 1, nacc_m1 = 2, pix_base = 8, pix_incr = 3, out_base = 5, maxpool = 0 -> read addresses 8, 9, 10, 11, 12, 13; ld_acc 2 cycles after reads 0 and 3; ld_res 3 cycles after reads 2 and 5; vwrite_enB at addresses 5 and 6; done returns high.
REQ-022 SHALL cover maxpool = 1, nout_m1 = 5, nacc_m1 = 0 -> 6 ld_res pulses, 6 ld_mp pulses, 2 writes at out_base and out_base + 1 (second group partial, 2 members).
REQ-023 SHALL cover pix_base = 1022, nacc_m1 = 3, MEM_ADDR_W = 10 -> read addresses 1022, 1023, 0, 1.
REQ-024 SHALL cover a second run pulse plus cfg changes while busy -> outputs identical to an undisturbed run.
REQ-025 SHALL cover rst low in the middle of ISSUE -> all enables 0 in the same cycle, done = 1, no writes after release, and a following run completes correctly.
